ysyx_exu_csr_seq: RTL

Sequencer directly upstream of the CSR register file in the execute stage. It accepts one CSR or privileged micro-op at a time from issue through a valid/ready handshake. It reads the old CSR value, computes the new value (CSRRW/S/C and immediate forms), and issues a single-cycle write or trap/return strobe to the CSR file. It then returns the rd result and a mandatory redirect PC downstream to commit.

---
 rtl/ysyx_exu_csr_seq_pkg.sv | 26 ++
 rtl/ysyx_exu_csr_alu.sv | 43 ++++
 rtl/ysyx_exu_csr_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_exu_csr_seq_pkg.sv
// rtl/ysyx_exu_csr_seq_pkg.sv - shared constants for the execute-stage CSR sequencer
package ysyx_exu_csr_seq_pkg;

    localparam int YSYX_XLEN = 32;
    localparam int YSYX_CSR_AW = 12;

    // CSR funct3 encodings; bit 2 selects the immediate form, bits 1:0 the operation
    localparam logic [2:0] YSYX_CSR_F3_RW  = 3'b001;
    localparam logic [2:0] YSYX_CSR_F3_RS  = 3'b010;
    localparam logic [2:0] YSYX_CSR_F3_RC  = 3'b011;
    localparam logic [2:0] YSYX_CSR_F3_RWI = 3'b101;
    localparam logic [2:0] YSYX_CSR_F3_RSI = 3'b110;
    localparam logic [2:0] YSYX_CSR_F3_RCI = 3'b111;

    // System micro-op kinds; code 3 is reserved and handled as an illegal op
    localparam logic [1:0] YSYX_SYS_CSR   = 2'd0;
    localparam logic [1:0] YSYX_SYS_ECALL = 2'd1;
    localparam logic [1:0] YSYX_SYS_MRET  = 2'd2;

    // Sequencer states
    localparam logic [1:0] YSYX_CSR_ST_IDLE = 2'd0;
    localparam logic [1:0] YSYX_CSR_ST_READ = 2'd1;
    localparam logic [1:0] YSYX_CSR_ST_EXEC = 2'd2;
    localparam logic [1:0] YSYX_CSR_ST_RESP = 2'd3;

endpackage

// File: rtl/ysyx_exu_csr_alu.sv
// rtl/ysyx_exu_csr_alu.sv - combinational CSR new-value, write-enable and legality decode
module ysyx_exu_csr_alu
    import ysyx_exu_csr_seq_pkg::*;
#(
    parameter int XLEN = YSYX_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    output logic [XLEN-1:0] new_val,
    output logic            wen,
    output logic            legal
);

    // Set/clear forms with a zero source are pure reads and must not write
    always_comb begin
        new_val = old_val;
        legal   = 1'b0;
        wen     = 1'b0;
        case (funct3)
            YSYX_CSR_F3_RW, YSYX_CSR_F3_RWI: begin
                legal   = 1'b1;
                new_val = src;
                wen     = 1'b1;
            end
            YSYX_CSR_F3_RS, YSYX_CSR_F3_RSI: begin
                legal   = 1'b1;
                new_val = old_val | src;
                wen     = !src_zero;
            end
            YSYX_CSR_F3_RC, YSYX_CSR_F3_RCI: begin
                legal   = 1'b1;
                new_val = old_val & ~src;
                wen     = !src_zero;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_exu_csr_seq.sv
// rtl/ysyx_exu_csr_seq.sv - IDLE/READ/EXEC/RESP sequencer in front of the CSR file
module ysyx_exu_csr_seq
    import ysyx_exu_csr_seq_pkg::*;
#(
    parameter int XLEN = YSYX_XLEN,
    parameter int R_W  = YSYX_CSR_AW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sys,
    input  logic [2:0]      in_funct3,
    input  logic [R_W-1:0]  in_csr_addr,
    input  logic [XLEN-1:0] in_src,
    input  logic            in_src_zero,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    output logic [R_W-1:0]  csr_rwaddr,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            csr_valid,
    output logic            csr_wen,
    output logic            csr_ecall,
    output logic            csr_mret,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_rdata,
    output logic [XLEN-1:0] out_npc
);

    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [1:0]      sys_q, sys_d;
    logic [2:0]      f3_q, f3_d;
    logic [R_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            src_zero_q, src_zero_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] npc_q, npc_d;

    logic [XLEN-1:0] alu_new;
    logic            alu_wen;
    logic            alu_legal;
    logic            is_csr;
    logic            is_exec;
    logic            is_resp;

    ysyx_exu_csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (f3_q),
        .old_val  (old_q),
        .src      (src_q),
        .src_zero (src_zero_q),
        .new_val  (alu_new),
        .wen      (alu_wen),
        .legal    (alu_legal)
    );

    // Next-state and datapath capture: latch op in IDLE, sample CSR file in READ, resolve npc in EXEC
    always_comb begin
        state_d    = state_q;
        sys_d      = sys_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        old_d      = old_q;
        tgt_d      = tgt_q;
        npc_d      = npc_q;
        case (state_q)
            YSYX_CSR_ST_IDLE: begin
                if (in_valid) begin
                    sys_d      = in_sys;
                    f3_d       = in_funct3;
                    addr_d     = in_csr_addr;
                    src_d      = in_src;
                    src_zero_d = in_src_zero;
                    rd_d       = in_rd;
                    pc_d       = in_pc;
                    state_d    = YSYX_CSR_ST_READ;
                end
            end
            YSYX_CSR_ST_READ: begin
                old_d   = csr_rdata;
                tgt_d   = (sys_q == YSYX_SYS_ECALL) ? csr_mtvec : csr_mepc;
                state_d = YSYX_CSR_ST_EXEC;
            end
            YSYX_CSR_ST_EXEC: begin
                if (sys_q == YSYX_SYS_ECALL || sys_q == YSYX_SYS_MRET) begin
                    npc_d = tgt_q;
                end else begin
                    npc_d = pc_q + INSN_BYTES;
                end
                state_d = YSYX_CSR_ST_RESP;
            end
            default: begin
                if (out_ready) begin
                    state_d = YSYX_CSR_ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; async reset clears everything so no stale op survives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= YSYX_CSR_ST_IDLE;
            sys_q      <= '0;
            f3_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            old_q      <= '0;
            tgt_q      <= '0;
            npc_q      <= '0;
        end else begin
            state_q    <= state_d;
            sys_q      <= sys_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            old_q      <= old_d;
            tgt_q      <= tgt_d;
            npc_q      <= npc_d;
        end
    end

    // Output decode; the write address stays on the latched address from READ through RESP
    always_comb begin
        is_csr     = (sys_q == YSYX_SYS_CSR);
        is_exec    = (state_q == YSYX_CSR_ST_EXEC);
        is_resp    = (state_q == YSYX_CSR_ST_RESP);
        in_ready   = (state_q == YSYX_CSR_ST_IDLE);
        csr_rwaddr = (state_q == YSYX_CSR_ST_IDLE) ? '0 : addr_q;
        csr_valid  = is_exec;
        csr_wen    = is_exec && is_csr && alu_wen;
        csr_ecall  = is_exec && (sys_q == YSYX_SYS_ECALL);
        csr_mret   = is_exec && (sys_q == YSYX_SYS_MRET);
        csr_wdata  = is_exec ? alu_new : '0;
        csr_pc     = is_exec ? pc_q : '0;
        out_valid  = is_resp;
        out_rd     = rd_q;
        out_rd_wen = is_resp && is_csr && alu_legal && (rd_q != 5'd0);
        out_rdata  = old_q;
        out_npc    = npc_q;
    end

endmodule
